// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front-end
package fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/flush; flush beats a same-cycle push
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter type T = logic
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  input  logic                   flush,
  output T                       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  // pointers and occupancy; flush empties the queue regardless of push/pop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= do_push ? wr + AW'(1) : wr;
      rd <= do_pop ? rd + AW'(1) : rd;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // entry storage, cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr] <= din;
    end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing credit-limited word fetches and buffering {pc,instr} for decode; FETCH_MISALIGN_CHECK_EN adds fetch_fault
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  , output logic      fetch_fault
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] pc, rsp_pc, target;
  logic [CW-1:0] inflight, inflight_nxt, drop, count, used;
  logic run, fault, req_hs, keep, pop, empty, full;
  fetch_entry_t head;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign target = redirect_pc;
  assign fetch_fault = fault;
  // a misaligned target latches the fault; the next aligned redirect clears it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) fault <= 1'b0;
    else if (redirect_valid) fault <= |redirect_pc[1:0];
`else
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign fault = 1'b0;
`endif
  assign used = count + inflight;
  assign imem_req_valid = run && !fault && used < CW'(FIFO_DEPTH);
  assign imem_req_addr = pc;
  assign req_hs = imem_req_valid && imem_req_ready;
  assign keep = imem_rsp_valid && drop == '0 && !redirect_valid;
  assign pop = out_valid && out_ready;
  assign out_valid = !empty;
  assign out_pc = head.pc;
  assign out_instr = head.instr;
  assign inflight_nxt = inflight + CW'(req_hs) - CW'(imem_rsp_valid);
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(keep),
    .din('{pc: rsp_pc, instr: imem_rsp_data}),
    .pop(pop),
    .flush(redirect_valid),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // PC tracking and outstanding accounting; a redirect marks every still-outstanding request stale
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      run <= 1'b0;
      pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      inflight <= '0;
      drop <= '0;
    end else begin
      run <= 1'b1;
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        pc <= target;
        rsp_pc <= target;
        drop <= inflight_nxt;
      end else begin
        pc <= req_hs ? pc + 32'd4 : pc;
        rsp_pc <= keep ? rsp_pc + 32'd4 : rsp_pc;
        drop <= (imem_rsp_valid && drop != '0) ? drop - CW'(1) : drop;
      end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized bench against a transaction-level fetch model
module tb_instruction_fetch;
  localparam int D = 2;
  logic clk = 1'b0, reset_n = 1'b0;
  logic redirect_valid = 1'b0, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
  logic imem_req_valid, out_valid;
  logic [31:0] imem_req_addr, out_instr, out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_fault;
`endif

  instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a; bit stale; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
  req_t mq[$];
  ent_t oq[$];
  logic [31:0] hs_log[$];
  int hs_cyc[$];
  logic [31:0] mpc;
  bit mfault, mstarted;
  int cyc, nreq, nvec, nerr;

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] logat(int i);
    return (i >= 0 && i < hs_log.size()) ? hs_log[i] : 32'hBAD0_0001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare DUT against the model, drive inputs, advance the model, wait for next negedge.
  task automatic cycle(input bit rdy, input bit rdir, input logic [31:0] tgt, input int lmin, input int lmax, input int mrdy_pct);
    bit exp_rv, rv, rhs;
    req_t r;
    exp_rv = mstarted && !mfault && (oq.size() + mq.size() < D);
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, mpc);
    chk("out_valid", out_valid, oq.size() != 0);
    if (oq.size() != 0) begin
      chk("out_pc", out_pc, oq[0].pc);
      chk("out_instr", out_instr, oq[0].ins);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("fetch_fault", fetch_fault, mfault);
`endif
    out_ready = rdy;
    redirect_valid = rdir;
    redirect_pc = tgt;
    imem_req_ready = $urandom_range(99) < mrdy_pct;
    rv = mq.size() > 0 && mq[0].due <= cyc;
    imem_rsp_valid = rv;
    imem_rsp_data = rv ? memf(mq[0].a) : $urandom;
    rhs = exp_rv && imem_req_ready;
    if (rdy && oq.size() != 0) begin
      hs_log.push_back(oq[0].pc);
      hs_cyc.push_back(cyc);
      void'(oq.pop_front());
    end
    if (rv) begin
      r = mq.pop_front();
      if (!r.stale && !rdir) oq.push_back('{r.a, memf(r.a)});
    end
    if (rhs) begin
      mq.push_back('{mpc, 1'b0, cyc + int'($urandom_range(lmax, lmin))});
      nreq++;
    end
    if (rdir) begin
      oq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      mfault = tgt[1:0] != 2'b00;
      mpc = tgt;
`else
      mpc = {tgt[31:2], 2'b00};
`endif
    end else if (rhs) mpc = mpc + 32'd4;
    mstarted = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_n(input int n, input bit rdy, input int lmin, input int lmax, input int mrdy_pct);
    for (int i = 0; i < n; i++) cycle(rdy, 1'b0, 32'h0, lmin, lmax, mrdy_pct);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (mq.size() != 0 || oq.size() != 0); i++) cycle(1'b1, 1'b0, 32'h0, 1, 1, 0);
    chk("drain_done", mq.size() + oq.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    out_ready = 1'b0;
    mq.delete();
    oq.delete();
    hs_log.delete();
    hs_cyc.delete();
    mpc = 32'h0;
    mfault = 1'b0;
    mstarted = 1'b0;
    nreq = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_fault", fetch_fault, 1'b0);
`endif
    reset_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    int idx, n0;
    bit ok, found;
    logic [31:0] p, tgt;
    nvec = 0;
    nerr = 0;
    @(negedge clk);
    do_reset();
    // latency 1, decode always ready
    run_n(12, 1'b1, 1, 1, 100);
    chk("t1_first_cycle", hs_cyc.size() > 0 ? hs_cyc[0] : -1, 3);
    chk("t1_pc0", logat(0), 32'h0);
    chk("t1_pc1", logat(1), 32'h4);
    chk("t1_pc2", logat(2), 32'h8);
    // decode stalled for 10 cycles
    run_n(10, 1'b0, 1, 1, 100);
    chk("t2_fetched_ahead", nreq - hs_log.size(), D);
    run_n(10, 1'b1, 1, 1, 100);
    ok = hs_log.size() > 5;
    foreach (hs_log[i]) if (hs_log[i] !== 32'(i * 4)) ok = 1'b0;
    chk("t2_contiguous", ok, 1'b1);
    // redirect with two fetches in flight
    drain();
    run_n(2, 1'b1, 5, 5, 100);
    chk("t3_inflight", mq.size(), 2);
    cycle(1'b1, 1'b1, 32'h100, 1, 1, 100);
    idx = hs_log.size();
    run_n(15, 1'b1, 1, 1, 100);
    chk("t3_first", logat(idx), 32'h100);
    chk("t3_second", logat(idx + 1), 32'h104);
    // redirect coinciding with a response and an output handshake
    found = 1'b0;
    p = 32'h0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (oq.size() != 0 && mq.size() != 0 && mq[0].due <= cyc) begin
        found = 1'b1;
        p = oq[0].pc;
        cycle(1'b1, 1'b1, 32'h300, 1, 1, 100);
      end else cycle(1'b1, 1'b0, 32'h0, 1, 1, 100);
    end
    chk("t4_found", found, 1'b1);
    idx = hs_log.size();
    run_n(10, 1'b1, 1, 1, 100);
    chk("t4_accepted_once", logat(idx - 1), p);
    chk("t4_target", logat(idx), 32'h300);
    // wrap-around
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1, 1, 100);
    idx = hs_log.size();
    run_n(15, 1'b1, 1, 1, 100);
    chk("t5_a", logat(idx), 32'hFFFF_FFF8);
    chk("t5_b", logat(idx + 1), 32'hFFFF_FFFC);
    chk("t5_c", logat(idx + 2), 32'h0000_0000);
    // misaligned redirect
    cycle(1'b1, 1'b1, 32'h102, 1, 1, 100);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("t6_fault_set", fetch_fault, 1'b1);
    n0 = nreq;
    run_n(6, 1'b1, 1, 1, 100);
    chk("t6_no_requests", nreq - n0, 0);
    cycle(1'b1, 1'b1, 32'h200, 1, 1, 100);
    chk("t6_fault_clear", fetch_fault, 1'b0);
    idx = hs_log.size();
    run_n(10, 1'b1, 1, 1, 100);
    chk("t6_target", logat(idx), 32'h200);
`else
    idx = hs_log.size();
    run_n(10, 1'b1, 1, 1, 100);
    chk("t6_forced_align", logat(idx), 32'h100);
`endif
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tgt = $urandom;
      if ($urandom_range(7) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(9) == 0) tgt[31:6] = '1;
      cycle($urandom_range(99) < 70, $urandom_range(99) < 3, tgt, 1, 4, 80);
    end
    // reset mid-operation once memory is quiet
    cycle(1'b1, 1'b1, 32'h40, 1, 1, 0);
    drain();
    do_reset();
    run_n(12, 1'b1, 1, 2, 100);
    chk("post_rst_pc0", logat(0), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
